// File: rtl/mv_pkg.sv
// Shared types and helpers for the matrix-vector BRAM fetch engine.
package mv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } mv_state_t;

    localparam int BRAM_WE_W  = 4;
    localparam int ADDR_SHIFT = 2;

    function automatic int mv_total(input int l_ram_size, input int row_size);
        return (row_size + 1) << l_ram_size;
    endfunction

endpackage

// File: rtl/mv_fetch_skid_fifo.sv
// First-word-fall-through skid FIFO for returning BRAM words and their tags.
module mv_fetch_skid_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_valid = (r_cnt != '0);
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_cnt;

    // The credit check upstream guarantees a push never meets a full FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/mv_bram_fetch.sv
// BRAM read engine streaming one vector block plus ROW_SIZE matrix rows.
// Optional stall counter enabled by defining MV_FETCH_STALL_CNT_EN.
module mv_bram_fetch
    import mv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int L_RAM_SIZE = 3,
    parameter int ROW_SIZE   = 8,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          BRAM_CLK,
    output logic [ADDR_W-1:0]             BRAM_ADDR,
    output logic [DATA_W-1:0]             BRAM_WRDATA,
    output logic [BRAM_WE_W-1:0]          BRAM_WE,
    input  logic [DATA_W-1:0]             BRAM_RDDATA,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(ROW_SIZE+1)-1:0] out_blk,
    output logic [L_RAM_SIZE-1:0]         out_idx,
    output logic                          out_last,
    output logic [15:0]                   stall_cycles
);

    localparam int TOTAL = mv_total(L_RAM_SIZE, ROW_SIZE);
    localparam int KW    = $clog2(TOTAL);
    localparam int IW    = KW + 1;
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = CW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << ADDR_SHIFT;

    mv_state_t          r_state;
    logic [IW-1:0]      r_issued;
    logic [ADDR_W-1:0]  r_next_addr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_busy;
    logic               r_done;
    logic [RD_LATENCY:0] r_pvld;
    logic [KW-1:0]      r_ptag [RD_LATENCY+1];
    logic [CW-1:0]      r_inflight;

    logic [CW-1:0]        w_fifo_cnt;
    logic                 w_fifo_valid;
    logic [KW+DATA_W-1:0] w_fifo_dout;
    logic [KW-1:0]        w_tag;
    logic [SW-1:0]        w_sum;
    logic                 w_pop;
    logic                 w_cap;
    logic                 w_issue;

    assign w_pop   = w_fifo_valid && out_ready;
    assign w_cap   = r_pvld[RD_LATENCY];
    // Words leaving this cycle free their slot for the next issue.
    assign w_sum   = SW'(r_inflight) + SW'(w_fifo_cnt) - SW'(w_pop);
    assign w_issue = (r_state == FETCH) && (w_sum < SW'(DEPTH));
    assign w_tag   = w_fifo_dout[DATA_W +: KW];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state     <= IDLE;
            r_issued    <= '0;
            r_next_addr <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FETCH;
                        r_busy      <= 1'b1;
                        r_issued    <= '0;
                        r_next_addr <= base_addr & ~(STEP - ADDR_W'(1));
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_addr      <= r_next_addr;
                        r_next_addr <= r_next_addr + STEP;
                        r_issued    <= r_issued + IW'(1);
                        if (r_issued == IW'(TOTAL - 1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag pipeline aligned with BRAM read latency.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_pvld     <= '0;
            r_inflight <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) r_ptag[i] <= '0;
        end else begin
            r_pvld     <= {r_pvld[RD_LATENCY-1:0], w_issue};
            r_ptag[0]  <= r_issued[KW-1:0];
            for (int i = 1; i <= RD_LATENCY; i++) r_ptag[i] <= r_ptag[i-1];
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_cap);
        end
    end

    mv_fetch_skid_fifo #(
        .WIDTH (KW + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (S_AXI_ACLK),
        .i_rst_n (S_AXI_ARESETN),
        .i_push  (w_cap),
        .i_din   ({r_ptag[RD_LATENCY], BRAM_RDDATA}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

`ifdef MV_FETCH_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_stall <= '0;
        end else if (r_state == IDLE && start) begin
            r_stall <= '0;
        end else if (r_busy && w_fifo_valid && !out_ready && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign BRAM_CLK    = ~S_AXI_ACLK;
    assign BRAM_ADDR   = r_addr;
    assign BRAM_WRDATA = '0;
    assign BRAM_WE     = '0;
    assign out_valid   = w_fifo_valid;
    assign out_data    = w_fifo_dout[DATA_W-1:0];
    assign out_blk     = w_tag[KW-1:L_RAM_SIZE];
    assign out_idx     = w_tag[L_RAM_SIZE-1:0];
    assign out_last    = w_fifo_valid && (w_tag == KW'(TOTAL - 1));

endmodule

// File: tb/tb_mv_bram_fetch.sv
// Bench for mv_bram_fetch: one default instance and one with RD_LATENCY = 3.
module tb_mv_bram_fetch;

    localparam int TOTAL = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rstn  [2];
    logic        start [2];
    logic [31:0] base  [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic        bclk  [2];
    logic [31:0] baddr [2];
    logic [31:0] wrd   [2];
    logic [3:0]  we    [2];
    logic [31:0] rdata [2];
    logic        valid [2];
    logic [31:0] odata [2];
    logic [3:0]  blk   [2];
    logic [2:0]  idx   [2];
    logic        last  [2];
    logic [15:0] stall [2];

    mv_bram_fetch u0 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn[0]), .start(start[0]),
        .base_addr(base[0]), .busy(busy[0]), .done(done[0]),
        .BRAM_CLK(bclk[0]), .BRAM_ADDR(baddr[0]), .BRAM_WRDATA(wrd[0]),
        .BRAM_WE(we[0]), .BRAM_RDDATA(rdata[0]), .out_valid(valid[0]),
        .out_ready(ready[0]), .out_data(odata[0]), .out_blk(blk[0]),
        .out_idx(idx[0]), .out_last(last[0]), .stall_cycles(stall[0])
    );

    mv_bram_fetch #(.RD_LATENCY(3)) u1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn[1]), .start(start[1]),
        .base_addr(base[1]), .busy(busy[1]), .done(done[1]),
        .BRAM_CLK(bclk[1]), .BRAM_ADDR(baddr[1]), .BRAM_WRDATA(wrd[1]),
        .BRAM_WE(we[1]), .BRAM_RDDATA(rdata[1]), .out_valid(valid[1]),
        .out_ready(ready[1]), .out_data(odata[1]), .out_blk(blk[1]),
        .out_idx(idx[1]), .out_last(last[1]), .stall_cycles(stall[1])
    );

    // Memory word at byte address a holds a>>2; data lags the address by RD_LATENCY cycles.
    logic [31:0] h0;
    logic [31:0] h1 [3];
    always @(posedge clk) begin
        h0    <= baddr[0];
        h1[0] <= baddr[1];
        h1[1] <= h1[0];
        h1[2] <= h1[1];
    end
    assign rdata[0] = h0 >> 2;
    assign rdata[1] = h1[2] >> 2;

    logic [39:0] q0 [$];
    logic [39:0] q1 [$];

    function automatic logic [39:0] exp_beat(logic [31:0] b, int k);
        logic [31:0] a;
        a = (b & ~32'h3) + 32'(4 * k);
        return {a >> 2, 4'(k >> 3), 3'(k & 7), (k == TOTAL - 1)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(int n, logic [31:0] b);
        for (int k = 0; k < TOTAL; k++) begin
            if (n == 0) q0.push_back(exp_beat(b, k));
            else q1.push_back(exp_beat(b, k));
        end
    endtask

    task automatic launch(int n, logic [31:0] b);
        start[n] = 1'b1;
        base[n]  = b;
        push_run(n, b);
        tick();
        start[n] = 1'b0;
    endtask

    task automatic wait_done(int n, int maxc, string tag);
        int c;
        c = 0;
        while (!done[n] && c < maxc) begin
            tick();
            c++;
        end
        checks++;
        assert (done[n] === 1'b1) else begin
            errors++;
            $error("FAIL %s: no done after %0d cycles", tag, c);
        end
    endtask

    task automatic check_reset(int n);
        chk("rst_busy", busy[n], 0);
        chk("rst_done", done[n], 0);
        chk("rst_valid", valid[n], 0);
        chk("rst_last", last[n], 0);
        chk("rst_addr", baddr[n], 0);
        chk("rst_data", odata[n], 0);
        chk("rst_blk", blk[n], 0);
        chk("rst_idx", idx[n], 0);
        chk("rst_stall", stall[n], 0);
    endtask

    int          beats [2];
    int          dones [2];
    logic        pstall [2];
    logic [39:0] ptup [2];
    logic        track1;
    int          issued1;
    int          maxout1;
    int          b1s;
    logic [31:0] paddr1;

    initial begin
        beats  = '{0, 0};
        dones  = '{0, 0};
        pstall = '{0, 0};
        ptup   = '{0, 0};
        track1 = 1'b0;
        issued1 = 0;
        maxout1 = 0;
        b1s = 0;
        paddr1 = '0;
    end

    always @(negedge clk) begin
        if (track1) begin
            if (baddr[1] != paddr1) issued1++;
            if (issued1 - (beats[1] - b1s) > maxout1) maxout1 = issued1 - (beats[1] - b1s);
        end
        paddr1 = baddr[1];
        for (int n = 0; n < 2; n++) begin
            logic [39:0] tup;
            logic [39:0] e;
            int sz;
            tup = {odata[n], blk[n], idx[n], last[n]};
            if (pstall[n] && rstn[n]) begin
                chk("hold_valid", valid[n], 1);
                chk("hold_data", tup, ptup[n]);
            end
            if (done[n]) dones[n]++;
            if (valid[n] && ready[n]) begin
                sz = (n == 0) ? q0.size() : q1.size();
                checks++;
                assert (sz != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: got beat %0h with nothing expected", tup);
                end
                if (sz != 0) begin
                    e = (n == 0) ? q0.pop_front() : q1.pop_front();
                    chk("beat", tup, e);
                end
                beats[n]++;
            end
            pstall[n] = valid[n] && !ready[n] && rstn[n];
            ptup[n] = tup;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int vc;
        int b0;
        int d0;
        logic [15:0] exp_stall;
        rstn  = '{0, 0};
        start = '{0, 0};
        base  = '{0, 0};
        ready = '{1, 1};
        repeat (3) tick();
        check_reset(0);
        check_reset(1);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        repeat (2) tick();

        // Default run, always ready
        b0 = beats[0];
        d0 = dones[0];
        launch(0, 32'h0);
        chk("busy_after_start", busy[0], 1);
        c = 0;
        while (!valid[0] && c < 20) begin
            tick();
            c++;
        end
        chk("first_valid_edge", c, 3);
        vc = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!valid[0]) break;
            vc++;
        end
        chk("valid_run_len", vc, TOTAL);
        chk("done_after_last", done[0], 1);
        tick();
        chk("done_one_cycle", done[0], 0);
        chk("busy_cleared", busy[0], 0);
        chk("t1_beats", beats[0] - b0, TOTAL);
        chk("t1_dones", dones[0] - d0, 1);
        chk("t1_sb_left", q0.size(), 0);

        // Latency 3, random backpressure
        ready[1] = 1'b0;
        b1s = beats[1];
        issued1 = 0;
        maxout1 = 0;
        track1 = 1'b1;
        launch(1, 32'h400);
        c = 0;
        while (!done[1] && c < 3000) begin
            ready[1] = ($urandom_range(0, 99) < 30);
            tick();
            c++;
        end
        checks++;
        assert (done[1] === 1'b1) else begin
            errors++;
            $error("FAIL t2_done: no done after %0d cycles", c);
        end
        track1 = 1'b0;
        ready[1] = 1'b1;
        tick();
        chk("t2_beats", beats[1] - b1s, TOTAL);
        chk("t2_sb_left", q1.size(), 0);
        chk("t2_issued", issued1, TOTAL);
        chk("t2_outstanding_le5", (maxout1 <= 5), 1);

        // Address wrap
        repeat (2) tick();
        b0 = beats[0];
        launch(0, 32'hFFFF_FFF0);
        tick();
        chk("wrap_addr_first", baddr[0], 32'hFFFF_FFF0);
        repeat (4) tick();
        chk("wrap_addr_zero", baddr[0], 32'h0);
        wait_done(0, 200, "t3_done");
        tick();
        chk("t3_beats", beats[0] - b0, TOTAL);
        chk("t3_sb_left", q0.size(), 0);

        // Starts while busy and in the done cycle are ignored
        b0 = beats[0];
        d0 = dones[0];
        launch(0, 32'h80);
        repeat (30) tick();
        start[0] = 1'b1;
        base[0] = 32'h1000;
        tick();
        start[0] = 1'b0;
        wait_done(0, 200, "t4_done");
        start[0] = 1'b1;
        base[0] = 32'h2000;
        tick();
        start[0] = 1'b0;
        repeat (100) tick();
        chk("t4_beats", beats[0] - b0, TOTAL);
        chk("t4_dones", dones[0] - d0, 1);
        chk("t4_idle_busy", busy[0], 0);
        chk("t4_idle_valid", valid[0], 0);
        chk("t4_sb_left", q0.size(), 0);

        // Reset in the middle of a run
        b0 = beats[0];
        launch(0, 32'h0);
        c = 0;
        while ((beats[0] - b0) < 20 && c < 200) begin
            tick();
            c++;
        end
        chk("t5_beats_at_reset", beats[0] - b0, 20);
        rstn[0] = 1'b0;
        #1;
        check_reset(0);
        q0.delete();
        d0 = dones[0];
        repeat (3) tick();
        rstn[0] = 1'b1;
        repeat (3) tick();
        chk("t5_no_done", dones[0] - d0, 0);
        chk("t5_busy_idle", busy[0], 0);
        b0 = beats[0];
        launch(0, 32'h0);
        wait_done(0, 200, "t5_done");
        tick();
        chk("t5_beats", beats[0] - b0, TOTAL);
        chk("t5_sb_left", q0.size(), 0);

        // Ten stalled cycles while valid
`ifdef MV_FETCH_STALL_CNT_EN
        exp_stall = 16'd10;
`else
        exp_stall = 16'd0;
`endif
        b0 = beats[0];
        launch(0, 32'h0);
        c = 0;
        while (!valid[0] && c < 20) begin
            tick();
            c++;
        end
        ready[0] = 1'b0;
        repeat (10) tick();
        ready[0] = 1'b1;
        wait_done(0, 200, "t6_done");
        chk("stall_at_done", stall[0], exp_stall);
        tick();
        chk("stall_hold", stall[0], exp_stall);
        chk("t6_beats", beats[0] - b0, TOTAL);
        b0 = beats[0];
        launch(0, 32'h0);
        chk("stall_clear", stall[0], 0);
        wait_done(0, 200, "t6b_done");
        tick();
        chk("t6b_beats", beats[0] - b0, TOTAL);
        chk("t6b_sb_left", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mv_bram_fetch.md
Name: mv_bram_fetch

Overview:
- Parametrised BRAM read engine feeding the matrix-vector PE array.
- On `start`, reads one vector block and then ROW_SIZE matrix rows, each of 2**L_RAM_SIZE words, from BRAM. It runs from a runtime base address and tolerates a configurable BRAM read latency.
- Streams the words to the PE side over a valid/ready interface with backpressure, and pulses `done` after the last word is accepted.
- Sits between the AXI-BRAM port and the PE array. It generalises the fixed 1-cycle, no-backpressure fetch used so far.

Parameters:
- DATA_W, 32, BRAM word and stream width.
- L_RAM_SIZE, 3, log2 of words per block (vector length N = 2**L_RAM_SIZE).
- ROW_SIZE, 8, number of matrix rows following the vector block.
- RD_LATENCY, 1, S_AXI_ACLK cycles from BRAM_ADDR driven to BRAM_RDDATA valid (1..4).
- ADDR_W, 32, BRAM byte-address width.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- base_addr  in  ADDR_W  byte address of word 0; latched on accepted start; bits [1:0] ignored.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- BRAM_CLK  out  1  equals ~S_AXI_ACLK.
- BRAM_ADDR  out  ADDR_W  byte address, registered.
- BRAM_WRDATA  out  DATA_W  constant 0.
- BRAM_WE  out  4  constant 0.
- BRAM_RDDATA  in  DATA_W  read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  PE side accepts word.
- out_data  out  DATA_W  word.
- out_blk  out  $clog2(ROW_SIZE+1)  0 = vector, r = matrix row r (1..ROW_SIZE).
- out_idx  out  L_RAM_SIZE  word index within block.
- out_last  out  1  final word of run.
- stall_cycles  out  16  see Optional Feature.

Behaviour:
- Reset values:
  - busy, done, out_valid, out_last all 0.
  - BRAM_ADDR = 0, out_data = 0, out_blk = 0, out_idx = 0, stall_cycles = 0.
  - FIFO emptied, in-flight counter cleared.
- Total words: TOTAL = (ROW_SIZE+1) << L_RAM_SIZE. Word k is at byte address base + 4k, incrementing modulo 2**ADDR_W.
- FSM states and transitions:
  - IDLE: start → FETCH; latch base_addr; busy ← 1. start while busy is ignored.
  - FETCH: issue reads until TOTAL addresses have been issued → DRAIN.
  - DRAIN: when the last word is handshaken → DONE.
  - DONE: done = 1 for one cycle, busy ← 0 → IDLE. A start in the DONE cycle is ignored.
- Read issue:
  - One address per cycle when issued + FIFO occupancy < FIFO_DEPTH = RD_LATENCY+2.
  - Otherwise BRAM_ADDR holds its value.
- Return path:
  - The word for the address driven in cycle k is captured at the end of cycle k+RD_LATENCY into the skid FIFO.
  - The FIFO is first-word-fall-through and drives out_*.
- Handshake:
  - Transfer occurs on out_valid && out_ready.
  - out_data, out_blk, out_idx and out_last are stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Latency:
  - start sampled at edge 0; first BRAM_ADDR at edge 1; first out_valid at edge RD_LATENCY+2.
  - With out_ready = 1, out_valid stays high for TOTAL consecutive cycles.
  - done pulses the cycle after the out_last transfer.
- FIFO never overflows and never drops a word, under any out_ready pattern.
- Reset mid-run: immediate return to the reset state. In-flight BRAM data is discarded, no done is issued, and the next start begins a fresh run.

Optional Feature:
- Macro: MV_FETCH_STALL_CNT_EN.
- When defined: stall_cycles counts cycles with out_valid && !out_ready during a run. It clears on accepted start, saturates at 16'hFFFF, and holds its value after done.
- When undefined: stall_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package mv_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, DONE).
  - Function computing TOTAL from L_RAM_SIZE and ROW_SIZE.
  - BRAM_WE width constant (4) and the byte-address shift constant (2).
- Sub-module mv_fetch_skid_fifo: parametrised FWFT FIFO with DATA_W+tag width and depth RD_LATENCY+2, exposing an occupancy count for credit checking.

Test Plan:
- Defaults, base_addr = 0, out_ready = 1, memory word k = k:
  - Expect 72 consecutive beats with out_data = 0..71 and BRAM_ADDR = 0x000..0x11C.
  - Expect out_blk/out_idx = (0,0)..(8,7) and out_last on beat 71.
  - Expect done exactly 1 cycle after beat 71; first out_valid at edge 3.
- Random out_ready at 30% duty, RD_LATENCY = 3, base_addr = 0x400:
  - Expect all 72 words in order, none lost or duplicated.
  - Expect outputs stable while stalled and no more than 5 reads outstanding.
- base_addr = 0xFFFF_FFF0: addresses wrap to 0x0 after 4 words; data follows the wrapped addresses.
- Second start pulsed mid-run and in the DONE cycle: expect exactly one 72-beat run and one done pulse.
- Assert S_AXI_ARESETN low at beat 20, release, then restart:
  - Expect all outputs at reset values immediately.
  - Expect a clean 72-beat run from word 0.
- With MV_FETCH_STALL_CNT_EN and out_ready low for exactly 10 cycles while valid: stall_cycles = 10 at done, and it clears on the next start.
